head_rowop_seq: RTL and testbench
=================================

// Module: head_rowop_seq
// PURPOSE
//  Parametrised successor to the fixed head sequencer. Fetches 16-bit instructions from an external
//  instruction memory and executes row-wise FP32 ops on a ROWS x COLS weight memory. Per instruction:
//  dst[c] = op(A[c], B[c]) for c = 0..COLS-1. FP arithmetic is delegated to an external FPU via a
//  valid/ready request and valid-only response. Sits between instrMem/weightMem and the shared FPU.
// PARAMETERS
//  IMEM_AW   4   instruction address width; program space is 2**IMEM_AW words
//  ROWS      4   weight-matrix rows, <=16
//  COLS      4   weight-matrix columns, >=1
//  DATA_W    32  weight word width (FP32)
//  WMEM_AW   $clog2(ROWS*COLS)   weight address width, derived
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous active-high reset
//  start          in   1        1-cycle pulse; begins execution at pc=0 when idle
//  busy           out  1        high from the cycle after an accepted start until the done pulse
//  done           out  1        1-cycle pulse on HALT, illegal op or pc wrap
//  err            out  1        sticky illegal-op / row-range flag; cleared by the next accepted start
//  imem_addr      out  IMEM_AW  instruction address; synchronous read, 1-cycle latency
//  imem_rdata     in   16       instruction word
//  wmem_addr      out  WMEM_AW  weight address = row*COLS + col
//  wmem_we        out  1        write strobe, one cycle per element
//  wmem_wdata     out  DATA_W   write data
//  wmem_rdata     in   DATA_W   read data; synchronous read, 1-cycle latency
//  fpu_req_valid  out  1        request valid; held until fpu_req_ready
//  fpu_req_ready  in   1        FPU accepts the request
//  fpu_op         out  2        0=ADD 1=MUL 2=SUB
//  fpu_a, fpu_b   out  DATA_W   operands, stable while valid
//  fpu_rsp_valid  in   1        result valid; one response per request, in order
//  fpu_rsp_data   in   DATA_W   result
// BEHAVIOUR
//  Encoding: [15:12] opcode, [11:8] dst row, [7:4] row A, [3:0] row B.
//   Opcodes: 0 HALT, 1 ADD, 2 MUL, 3 SUB, 4 COPY (dst=A; no FPU, B ignored). Others illegal.
//  Reset: FSM=IDLE, pc=0, col=0. busy, done, err, wmem_we, fpu_req_valid = 0. Addresses and data = 0.
//   A reset mid-instruction aborts with no further write. Elements already written stay written.
//  FSM: IDLE -start-> FETCH (imem_addr=pc) -> DECODE (latch instr).
//   DECODE cases:
//    HALT                      -> DONE
//    illegal op, or any used row >= ROWS -> err=1, DONE
//    otherwise                 -> col=0, RD_A
//   Element states:
//    RD_A   drive A addr
//    RD_B   drive B addr, capture A
//    ISSUE  capture B; valid=1 until the ready handshake
//    WAIT   wait for fpu_rsp_valid
//    WB     wmem_we=1, wdata=result
//   COPY path: RD_A -> CAPA -> WB.
//   After WB:
//    col<COLS-1 -> col+1, RD_A
//    else pc+1 -> FETCH
//    pc wraps from 2**IMEM_AW-1 to 0 -> DONE (no HALT seen)
//  DONE: done=1 for 1 cycle, busy=0 the same cycle, then IDLE.
//  start while busy is ignored. start in the DONE cycle is ignored.
//  fpu_rsp_valid outside WAIT is ignored. fpu_req_ready outside ISSUE is ignored.
//  Min element cost with zero-wait FPU (ready in ISSUE, rsp the next cycle) = 5 cycles. Per instr +2 fetch/decode.
//  dst may equal A or B: each element is read before it is written. Columns stay independent.
// STRUCTURE
//  Shared package head_pkg: opcode localparams (OP_HALT..OP_COPY), FPU op codes, instruction field
//   slices, FSM state enum.
//  Single module; no sub-module. The FPU and both memories are external.
// TESTING (bench supplies sync-read memories and an FPU model with configurable ready/rsp delay)
//  1 All weights 0x3f800000. Program {0x1012, 0x0000} (ADD r0=r1+r2, HALT)
//    -> row0 = 0x40000000, other rows unchanged, done after 2+4*5+2 cycles with a zero-wait FPU.
//  2 Program {0x4130, 0x0000} with row3 = 0x40400000
//    -> row1 = 0x40400000, fpu_req_valid never asserted.
//  3 Program {0x7000}
//    -> err=1, done pulse, no wmem_we. A next start with a legal program clears err.
//  4 FPU ready delayed 3 cycles and rsp delayed 4, ADD r0=r0+r0
//    -> fpu_a/b stable while valid, row0 = 0x40000000, exactly COLS requests.
//  5 Program with no HALT (all 0x2111) -> pc wraps, done at wrap, busy low after.
//  6 rst asserted in the WAIT of the 2nd column -> all outputs 0 next cycle. Only col0 written. start then works.

Source files
------------

// File: rtl/head_pkg.sv
// Shared definitions for the row-op head sequencer: opcodes, FPU op codes,
// instruction field extraction and FSM state codes.
package head_pkg;

   localparam logic [3:0] OP_HALT = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_COPY = 4'd4;

   localparam logic [1:0] FPU_ADD = 2'd0;
   localparam logic [1:0] FPU_MUL = 2'd1;
   localparam logic [1:0] FPU_SUB = 2'd2;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE   = 4'd0;
   localparam state_t S_FETCH  = 4'd1;
   localparam state_t S_DECODE = 4'd2;
   localparam state_t S_RD_A   = 4'd3;
   localparam state_t S_RD_B   = 4'd4;
   localparam state_t S_CAPA   = 4'd5;
   localparam state_t S_ISSUE  = 4'd6;
   localparam state_t S_WAIT   = 4'd7;
   localparam state_t S_WB     = 4'd8;
   localparam state_t S_DONE   = 4'd9;

   function automatic logic [3:0] instr_op(input logic [15:0] instr);
      return instr[15:12];
   endfunction

   function automatic logic [3:0] instr_dst(input logic [15:0] instr);
      return instr[11:8];
   endfunction

   function automatic logic [3:0] instr_ra(input logic [15:0] instr);
      return instr[7:4];
   endfunction

   function automatic logic [3:0] instr_rb(input logic [15:0] instr);
      return instr[3:0];
   endfunction

   function automatic logic [1:0] fpu_code(input logic [3:0] op);
      case (op)
         OP_MUL:  return FPU_MUL;
         OP_SUB:  return FPU_SUB;
         default: return FPU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/head_rowop_seq.sv
// Row-wise FP32 instruction sequencer: fetches instructions, streams row elements
// through an external FPU and writes results back to the weight memory.
module head_rowop_seq
   import head_pkg::*;
#(
   parameter int IMEM_AW = 4,
   parameter int ROWS    = 4,
   parameter int COLS    = 4,
   parameter int DATA_W  = 32,
   parameter int WMEM_AW = $clog2(ROWS*COLS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [15:0]        imem_rdata,
   output logic [WMEM_AW-1:0] wmem_addr,
   output logic               wmem_we,
   output logic [DATA_W-1:0]  wmem_wdata,
   input  logic [DATA_W-1:0]  wmem_rdata,
   output logic               fpu_req_valid,
   input  logic               fpu_req_ready,
   output logic [1:0]         fpu_op,
   output logic [DATA_W-1:0]  fpu_a,
   output logic [DATA_W-1:0]  fpu_b,
   input  logic               fpu_rsp_valid,
   input  logic [DATA_W-1:0]  fpu_rsp_data
);

   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [IMEM_AW-1:0] PC_LAST  = '1;
   localparam logic [COL_W-1:0]   COL_LAST = COL_W'(COLS - 1);

   state_t              state;
   logic [IMEM_AW-1:0]  pc;
   logic [COL_W-1:0]    col;
   logic [15:0]         instr;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   logic [DATA_W-1:0]   res_q;
   logic                issue_first;
   logic                err_q;

   logic [3:0]          dec_op;
   logic                dec_bad;

   function automatic logic row_ok(input logic [3:0] row);
      return int'(row) < ROWS;
   endfunction

   function automatic logic [WMEM_AW-1:0] elem_addr(input logic [3:0] row,
                                                    input logic [COL_W-1:0] c);
      return WMEM_AW'(int'(row) * COLS + int'(c));
   endfunction

   // COPY never touches the B row, so an out-of-range B field is harmless there.
   assign dec_op  = instr_op(imem_rdata);
   assign dec_bad = (dec_op > OP_COPY) || !row_ok(instr_dst(imem_rdata)) ||
                    !row_ok(instr_ra(imem_rdata)) ||
                    ((dec_op != OP_COPY) && !row_ok(instr_rb(imem_rdata)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= '0;
         col         <= '0;
         instr       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         issue_first <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_FETCH;
                  pc    <= '0;
                  col   <= '0;
                  err_q <= 1'b0;
               end
            end
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               instr <= imem_rdata;
               col   <= '0;
               if (dec_op == OP_HALT) begin
                  state <= S_DONE;
               end else if (dec_bad) begin
                  err_q <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_RD_A;
               end
            end
            S_RD_A: state <= (instr_op(instr) == OP_COPY) ? S_CAPA : S_RD_B;
            S_RD_B: begin
               a_q         <= wmem_rdata;
               issue_first <= 1'b1;
               state       <= S_ISSUE;
            end
            S_CAPA: begin
               res_q <= wmem_rdata;
               state <= S_WB;
            end
            // B arrives on the first ISSUE cycle and is held in b_q for any stall.
            S_ISSUE: begin
               issue_first <= 1'b0;
               if (issue_first) b_q <= wmem_rdata;
               if (fpu_req_ready) state <= S_WAIT;
            end
            S_WAIT: begin
               if (fpu_rsp_valid) begin
                  res_q <= fpu_rsp_data;
                  state <= S_WB;
               end
            end
            S_WB: begin
               if (col != COL_LAST) begin
                  col   <= col + COL_W'(1);
                  state <= S_RD_A;
               end else begin
                  pc    <= pc + IMEM_AW'(1);
                  state <= (pc == PC_LAST) ? S_DONE : S_FETCH;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      wmem_addr = '0;
      case (state)
         S_RD_A:          wmem_addr = elem_addr(instr_ra(instr), col);
         S_RD_B, S_ISSUE: wmem_addr = elem_addr(instr_rb(instr), col);
         S_WB:            wmem_addr = elem_addr(instr_dst(instr), col);
         default:         wmem_addr = '0;
      endcase
   end

   assign imem_addr     = pc;
   assign wmem_we       = (state == S_WB);
   assign wmem_wdata    = wmem_we ? res_q : '0;
   assign fpu_req_valid = (state == S_ISSUE);
   assign fpu_op        = fpu_code(instr_op(instr));
   assign fpu_a         = a_q;
   assign fpu_b         = issue_first ? wmem_rdata : b_q;
   assign busy          = (state != S_IDLE) && (state != S_DONE);
   assign done          = (state == S_DONE);
   assign err           = err_q;

endmodule

// File: tb/tb_head_rowop_seq.sv
// Bench for head_rowop_seq: sync-read memories, delay-configurable FPU model and
// a program-level reference interpreter.
module tb_head_rowop_seq;

   localparam int IMEM_AW = 4;
   localparam int ROWS    = 4;
   localparam int COLS    = 4;
   localparam int DATA_W  = 32;
   localparam int WMEM_AW = 4;
   localparam int NW      = ROWS * COLS;
   localparam int NI      = 2 ** IMEM_AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic busy, done, err;
   logic [IMEM_AW-1:0] imem_addr;
   logic [15:0] imem_rdata;
   logic [WMEM_AW-1:0] wmem_addr;
   logic wmem_we;
   logic [DATA_W-1:0] wmem_wdata, wmem_rdata;
   logic fpu_req_valid, fpu_req_ready;
   logic [1:0] fpu_op;
   logic [DATA_W-1:0] fpu_a, fpu_b;
   logic fpu_rsp_valid;
   logic [DATA_W-1:0] fpu_rsp_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   head_rowop_seq #(.IMEM_AW(IMEM_AW), .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W),
                    .WMEM_AW(WMEM_AW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .wmem_addr(wmem_addr), .wmem_we(wmem_we), .wmem_wdata(wmem_wdata),
      .wmem_rdata(wmem_rdata),
      .fpu_req_valid(fpu_req_valid), .fpu_req_ready(fpu_req_ready), .fpu_op(fpu_op),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_rsp_valid(fpu_rsp_valid),
      .fpu_rsp_data(fpu_rsp_data)
   );

   // FP32 <-> real for the exactly representable values used here
   function automatic real fp2r(input logic [31:0] x);
      logic [63:0] d;
      int e;
      if (x[30:0] == 31'd0) return 0.0;
      e = int'(x[30:23]) - 127 + 1023;
      d = {x[31], e[10:0], x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2fp(input real r);
      logic [63:0] d;
      int e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fpu_calc(input logic [1:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
      case (code)
         2'd0:    return r2fp(fp2r(a) + fp2r(b));
         2'd1:    return r2fp(fp2r(a) * fp2r(b));
         2'd2:    return r2fp(fp2r(a) - fp2r(b));
         default: return 32'hdeadbeef;
      endcase
   endfunction

   // Memories
   logic [15:0] imem [NI];
   logic [31:0] wmem [NW];
   logic [31:0] wmem_init [NW];
   logic load = 1'b0;

   always @(posedge clk) imem_rdata <= imem[imem_addr];

   always @(posedge clk) begin
      if (load) wmem <= wmem_init;
      else if (wmem_we) wmem[wmem_addr] <= wmem_wdata;
      wmem_rdata <= wmem[wmem_addr];
   end

   // FPU model
   int rdy_dly = 0;
   int rsp_dly = 1;
   int vcnt = 0;
   logic pend = 1'b0;
   int pcnt = 0;
   logic [31:0] pres = '0;
   logic hold_v = 1'b0;
   logic [31:0] hold_a, hold_b;
   logic [1:0] hold_op;
   int n_req = 0;
   int n_we = 0;
   int n_unstable = 0;

   assign fpu_req_ready = fpu_req_valid && (vcnt >= rdy_dly);
   assign fpu_rsp_valid = pend && (pcnt == 1);
   assign fpu_rsp_data  = fpu_rsp_valid ? pres : 32'h0;

   always @(posedge clk) begin
      if (rst) begin
         vcnt   <= 0;
         pend   <= 1'b0;
         pcnt   <= 0;
         hold_v <= 1'b0;
      end else begin
         vcnt    <= (fpu_req_valid && !fpu_req_ready) ? vcnt + 1 : 0;
         hold_v  <= fpu_req_valid && !fpu_req_ready;
         hold_a  <= fpu_a;
         hold_b  <= fpu_b;
         hold_op <= fpu_op;
         if (fpu_req_valid && fpu_req_ready) begin
            pend <= 1'b1;
            pcnt <= rsp_dly;
            pres <= fpu_calc(fpu_op, fpu_a, fpu_b);
         end else if (fpu_rsp_valid) begin
            pend <= 1'b0;
            pcnt <= 0;
         end else if (pend) begin
            pcnt <= pcnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (fpu_req_valid && fpu_req_ready) n_req <= n_req + 1;
      if (wmem_we) n_we <= n_we + 1;
      if (hold_v && fpu_req_valid &&
          (fpu_a !== hold_a || fpu_b !== hold_b || fpu_op !== hold_op))
         n_unstable <= n_unstable + 1;
   end

   // Reference interpreter
   logic [15:0] prog [NI];
   logic [31:0] exp_w [NW];
   logic exp_err;
   int exp_reqs, exp_cyc;

   logic [31:0] vals [8] = '{32'h3f800000, 32'h40000000, 32'h3f000000, 32'hbf800000,
                             32'h40400000, 32'hc0000000, 32'h3fc00000, 32'h3e800000};

   task automatic model_run();
      int pc;
      logic [3:0] op, d, a, b;
      real x, y;
      exp_w = wmem_init;
      exp_err = 1'b0;
      exp_reqs = 0;
      exp_cyc = 0;
      pc = 0;
      forever begin
         exp_cyc += 2;
         {op, d, a, b} = prog[pc];
         if (op == 4'd0) break;
         if (op > 4'd4 || d >= ROWS || a >= ROWS || (op != 4'd4 && b >= ROWS)) begin
            exp_err = 1'b1;
            break;
         end
         for (int c = 0; c < COLS; c++) begin
            if (op == 4'd4) begin
               exp_w[int'(d)*COLS + c] = exp_w[int'(a)*COLS + c];
               exp_cyc += 3;
            end else begin
               x = fp2r(exp_w[int'(a)*COLS + c]);
               y = fp2r(exp_w[int'(b)*COLS + c]);
               exp_w[int'(d)*COLS + c] = (op == 4'd1) ? r2fp(x + y) :
                                         (op == 4'd2) ? r2fp(x * y) : r2fp(x - y);
               exp_cyc += 5;
               exp_reqs++;
            end
         end
         pc++;
         if (pc == NI) break;
      end
   endtask

   task automatic commit_prog();
      for (int i = 0; i < NI; i++) imem[i] = prog[i];
   endtask

   task automatic clear_prog();
      for (int i = 0; i < NI; i++) prog[i] = 16'h0000;
   endtask

   task automatic load_weights();
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
   endtask

   task automatic check_mem(input string name);
      for (int i = 0; i < NW; i++) begin
         checks++;
         if (wmem[i] !== exp_w[i]) begin
            errors++;
            $display("FAIL %s word %0d got %h expected %h", name, i, wmem[i], exp_w[i]);
         end
      end
   endtask

   task automatic run_prog(input bit spam, output int bcyc, output logic err_first);
      bit ok;
      bcyc = 0;
      ok = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = spam;
      err_first = err;
      for (int i = 0; i < 4000; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (busy) bcyc++;
         @(negedge clk);
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL run_timeout done got 0 after 4000 cycles required 1");
      end else begin
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done got %b required 0", busy);
         end
      end
      @(negedge clk) start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL after_done done=%b busy=%b required 0 0", done, busy);
      end
   endtask

   task automatic check_int(input string name, input int got, input int req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, req);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, err, wmem_we, fpu_req_valid} !== 5'b0 || imem_addr !== '0 ||
          wmem_addr !== '0 || wmem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b err=%b we=%b v=%b ia=%h wa=%h wd=%h required all 0",
                  busy, done, err, wmem_we, fpu_req_valid, imem_addr, wmem_addr, wmem_wdata);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, err} !== 3'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b done=%b err=%b required 0", busy, done, err);
      end
   endtask

   task automatic test_add_halt();
      int bc, rb;
      logic ef;
      for (int i = 0; i < NW; i++) wmem_init[i] = 32'h3f800000;
      clear_prog();
      prog[0] = 16'h1012;
      commit_prog();
      load_weights();
      rdy_dly = 0;
      rsp_dly = 1;
      model_run();
      rb = n_req;
      run_prog(1'b0, bc, ef);
      check_mem("add_halt");
      check_int("add_halt_row0_c0", int'(wmem[0] == 32'h40000000), 1);
      check_int("add_halt_cycles", bc, 2 + COLS*5 + 2);
      check_int("add_halt_reqs", n_req - rb, COLS);
      check_int("add_halt_err", int'(err), 0);
   endtask

   task automatic test_copy();
      int bc, rb;
      logic ef;
      for (int i = 0; i < NW; i++) wmem_init[i] = vals[$urandom_range(0, 7)];
      for (int c = 0; c < COLS; c++) wmem_init[3*COLS + c] = 32'h40400000;
      clear_prog();
      prog[0] = 16'h4130;
      commit_prog();
      load_weights();
      model_run();
      rb = n_req;
      run_prog(1'b0, bc, ef);
      check_mem("copy");
      check_int("copy_row1_c2", int'(wmem[1*COLS + 2] == 32'h40400000), 1);
      check_int("copy_reqs", n_req - rb, 0);
      check_int("copy_cycles", bc, exp_cyc);
   endtask

   task automatic test_illegal();
      int bc, rw;
      logic ef;
      clear_prog();
      prog[0] = 16'h7000;
      commit_prog();
      load_weights();
      model_run();
      rw = n_we;
      run_prog(1'b0, bc, ef);
      check_int("illegal_err", int'(err), 1);
      check_int("illegal_writes", n_we - rw, 0);
      check_int("illegal_cycles", bc, 2);
      repeat (3) @(negedge clk);
      check_int("illegal_err_sticky", int'(err), 1);
      // out-of-range dst row
      prog[0] = 16'h1912;
      commit_prog();
      run_prog(1'b0, bc, ef);
      check_int("row_range_err", int'(err), 1);
      check_int("row_range_writes", n_we - rw, 0);
      prog[0] = 16'h4130;
      commit_prog();
      model_run();
      run_prog(1'b0, bc, ef);
      check_int("err_cleared_at_start", int'(ef), 0);
      check_int("err_after_legal", int'(err), 0);
      check_mem("legal_after_err");
   endtask

   task automatic test_slow_fpu();
      int bc, rb, ru;
      logic ef;
      for (int i = 0; i < NW; i++) wmem_init[i] = 32'h3f800000;
      clear_prog();
      prog[0] = 16'h1000;
      commit_prog();
      load_weights();
      rdy_dly = 3;
      rsp_dly = 4;
      model_run();
      rb = n_req;
      ru = n_unstable;
      run_prog(1'b0, bc, ef);
      check_mem("slow_fpu");
      check_int("slow_fpu_row0_c3", int'(wmem[3] == 32'h40000000), 1);
      check_int("slow_fpu_reqs", n_req - rb, COLS);
      check_int("slow_fpu_stable", n_unstable - ru, 0);
      rdy_dly = 0;
      rsp_dly = 1;
   endtask

   task automatic test_wrap();
      int bc;
      logic ef;
      for (int i = 0; i < NW; i++) wmem_init[i] = vals[$urandom_range(0, 1) * 3];
      for (int i = 0; i < NI; i++) prog[i] = 16'h2111;
      commit_prog();
      load_weights();
      model_run();
      run_prog(1'b0, bc, ef);
      check_mem("wrap");
      check_int("wrap_cycles", bc, NI * (2 + COLS*5));
      check_int("wrap_pc", int'(imem_addr), 0);
      check_int("wrap_err", int'(err), 0);
   endtask

   task automatic test_reset_mid();
      int rb, rw, bc;
      bit hit;
      logic ef;
      for (int i = 0; i < NW; i++) wmem_init[i] = 32'h3f800000;
      for (int c = 0; c < COLS; c++) wmem_init[c] = 32'h41000000;
      clear_prog();
      prog[0] = 16'h1012;
      commit_prog();
      load_weights();
      rdy_dly = 0;
      rsp_dly = 4;
      rb = n_req;
      rw = n_we;
      hit = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (n_req - rb == 2) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL mid_reset_wait second request not seen within 300 cycles");
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, err, wmem_we, fpu_req_valid} !== 5'b0 || imem_addr !== '0 ||
          wmem_addr !== '0 || wmem_wdata !== '0 || fpu_a !== '0 || fpu_b !== '0 ||
          fpu_op !== 2'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs got busy=%b done=%b we=%b v=%b wa=%h wd=%h a=%h b=%h required all 0",
                  busy, done, wmem_we, fpu_req_valid, wmem_addr, wmem_wdata, fpu_a, fpu_b);
      end
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check_int("mid_reset_writes", n_we - rw, 1);
      exp_w = wmem_init;
      exp_w[0] = 32'h40000000;
      check_mem("mid_reset_mem");
      rsp_dly = 1;
      wmem_init = wmem;
      model_run();
      run_prog(1'b0, bc, ef);
      check_mem("after_mid_reset");
      check_int("after_mid_reset_cycles", bc, exp_cyc);
   endtask

   task automatic test_random();
      int bc, rb, len;
      logic ef;
      logic [3:0] op, d, a, b;
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < NW; i++) wmem_init[i] = vals[$urandom_range(0, 7)];
         clear_prog();
         len = $urandom_range(1, 5);
         for (int k = 0; k < len; k++) begin
            op = 4'($urandom_range(1, 4));
            d = 4'($urandom_range(0, ROWS-1));
            a = 4'($urandom_range(0, ROWS-1));
            b = 4'($urandom_range(0, 15));
            if (op != 4'd4 && b >= ROWS) b = 4'($urandom_range(0, ROWS-1));
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(5, 15));
            if ($urandom_range(0, 9) == 0) d = 4'($urandom_range(ROWS, 15));
            prog[k] = {op, d, a, b};
         end
         commit_prog();
         load_weights();
         rdy_dly = (t < 2) ? 0 : $urandom_range(0, 3);
         rsp_dly = (t < 2) ? 1 : $urandom_range(1, 4);
         model_run();
         rb = n_req;
         // last passes hold start high throughout, including the done cycle
         run_prog(t >= 4, bc, ef);
         check_mem("random");
         check_int("random_err", int'(err), int'(exp_err));
         check_int("random_reqs", n_req - rb, exp_reqs);
         if (rdy_dly == 0 && rsp_dly == 1) check_int("random_cycles", bc, exp_cyc);
      end
      rdy_dly = 0;
      rsp_dly = 1;
   endtask

   initial begin
      for (int i = 0; i < NI; i++) imem[i] = 16'h0000;
      for (int i = 0; i < NW; i++) wmem_init[i] = 32'h0;
      test_reset();
      test_add_halt();
      test_copy();
      test_illegal();
      test_slow_fpu();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
